// File: rtl/conv_channel_scheduler.sv
// -----------------------------------------------------------------------------
// conv_channel_scheduler
//
// Sequences one shared row-parallel convolution engine across NUM_KERNELS
// output channels for a single input feature map. For every channel it
// loads the kernel one column per cycle, streams the image columns,
// forwards the engine results to the output buffer tagged with channel and
// column, and stalls issue while the output buffer is not ready.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, abort    layer start (sampled in IDLE) / synchronous abort to IDLE
//   busy, done      high outside IDLE / one-cycle pulse at end of layer
//   kern_idx        current channel (high part of kernel/image memory address)
//   kern_col        kernel column being loaded
//   img_col         image column being issued
//   kernel_load     engine kernel-load strobe
//   valid_in        engine input valid (kernel column or image column)
//   eng_valid_out   engine result valid for one output column
//   out_ready       output buffer can accept new issue
//   out_wr/ch/col   output-buffer write strobe, channel tag, output column
//   err             sticky protocol error (unexpected or surplus result)
// -----------------------------------------------------------------------------
module conv_channel_scheduler #(
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int NUM_KERNELS = 4,
    localparam int OUT_COLS   = IMAGE_SIZE - KERNEL_SIZE + 1,
    localparam int KW         = $clog2(KERNEL_SIZE),
    localparam int IW         = $clog2(IMAGE_SIZE),
    localparam int CW         = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] kern_idx,
    output logic [KW-1:0] kern_col,
    output logic [IW-1:0] img_col,
    output logic          kernel_load,
    output logic          valid_in,
    input  logic          eng_valid_out,
    input  logic          out_ready,
    output logic          out_wr,
    output logic [CW-1:0] out_ch,
    output logic [IW-1:0] out_col,
    output logic          err
);

    // Result counter is one bit wider than a column index so it can hold
    // OUT_COLS itself, which marks "all results of this channel received".
    localparam int RW = IW + 1;

    localparam logic [KW-1:0] K_LAST   = KW'(KERNEL_SIZE - 1);
    localparam logic [IW-1:0] I_LAST   = IW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_KERNELS - 1);
    localparam logic [RW-1:0] RES_FULL = RW'(OUT_COLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_K,
        ST_STREAM,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t          state;
    logic [RW-1:0]   res_cnt;

    logic            capture_window;
    logic            capture;
    logic            err_set;
    logic            start_accept;

    // Results are only legal while the engine is streaming or draining, and
    // only until the channel has produced OUT_COLS of them.
    assign capture_window = (state == ST_STREAM) || (state == ST_DRAIN);
    assign capture        = eng_valid_out && capture_window && (res_cnt < RES_FULL);
    assign err_set        = eng_valid_out && !capture;
    assign start_accept   = (state == ST_IDLE) && start && !abort;

    // Zero-cycle capture: the write goes out in the same cycle the engine
    // presents the result.
    assign out_wr  = capture;
    assign out_ch  = kern_idx;
    assign out_col = res_cnt[IW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            kern_idx    <= '0;
            kern_col    <= '0;
            img_col     <= '0;
            kernel_load <= 1'b0;
            valid_in    <= 1'b0;
            res_cnt     <= '0;
            err         <= 1'b0;
        end else begin
            // A protocol error in the same cycle as an accepted start still
            // records, so the error is never silently lost.
            if (err_set) begin
                err <= 1'b1;
            end else if (start_accept) begin
                err <= 1'b0;
            end

            done <= 1'b0;

            if (abort) begin
                state       <= ST_IDLE;
                busy        <= 1'b0;
                kern_idx    <= '0;
                kern_col    <= '0;
                img_col     <= '0;
                kernel_load <= 1'b0;
                valid_in    <= 1'b0;
                res_cnt     <= '0;
            end else begin
                if (capture) begin
                    res_cnt <= res_cnt + RW'(1);
                end

                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state       <= ST_LOAD_K;
                            busy        <= 1'b1;
                            kernel_load <= 1'b1;
                            valid_in    <= 1'b1;
                            kern_idx    <= '0;
                            kern_col    <= '0;
                            img_col     <= '0;
                            res_cnt     <= '0;
                        end
                    end

                    ST_LOAD_K: begin
                        if (kern_col == K_LAST) begin
                            state       <= ST_STREAM;
                            kernel_load <= 1'b0;
                            valid_in    <= out_ready;
                            img_col     <= '0;
                        end else begin
                            kern_col <= kern_col + KW'(1);
                        end
                    end

                    ST_STREAM: begin
                        // valid_in marks an issue in the current cycle; the
                        // column only advances once it has actually gone out.
                        if (valid_in && (img_col == I_LAST)) begin
                            state    <= ST_DRAIN;
                            valid_in <= 1'b0;
                        end else begin
                            if (valid_in) begin
                                img_col <= img_col + IW'(1);
                            end
                            valid_in <= out_ready;
                        end
                    end

                    ST_DRAIN: begin
                        if (res_cnt == RES_FULL) begin
                            state <= ST_NEXT;
                        end
                    end

                    ST_NEXT: begin
                        if (kern_idx == CH_LAST) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_LOAD_K;
                            kern_idx    <= kern_idx + CW'(1);
                            kernel_load <= 1'b1;
                            valid_in    <= 1'b1;
                            kern_col    <= '0;
                            img_col     <= '0;
                            res_cnt     <= '0;
                        end
                    end

                    ST_DONE: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        kern_idx <= '0;
                        kern_col <= '0;
                        img_col  <= '0;
                        res_cnt  <= '0;
                    end

                    default: begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        kernel_load <= 1'b0;
                        valid_in    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_channel_scheduler
//
// Directed bench for conv_channel_scheduler with default parameters. A small
// engine model turns every image issue from column KERNEL_SIZE-1 onward into
// a result three cycles later, tagged with the channel and output column the
// bench expects for it. A negedge monitor tracks kernel loads, image issues
// and output writes against those bench-side expectations.
// -----------------------------------------------------------------------------
module tb_conv_channel_scheduler;

    localparam int K  = 5;
    localparam int I  = 28;
    localparam int N  = 4;
    localparam int OC = I - K + 1;      // 24 results per channel
    localparam int LAYER_CYCLES = 153;  // start at cycle 0 -> done in cycle 153

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic       eng_valid_out;
    logic       busy, done, kernel_load, valid_in, out_wr, err;
    logic [1:0] kern_idx, out_ch;
    logic [2:0] kern_col;
    logic [4:0] img_col, out_col;

    always #5 clk = ~clk;

    conv_channel_scheduler #(
        .KERNEL_SIZE (K),
        .IMAGE_SIZE  (I),
        .NUM_KERNELS (N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .kern_idx      (kern_idx),
        .kern_col      (kern_col),
        .img_col       (img_col),
        .kernel_load   (kernel_load),
        .valid_in      (valid_in),
        .eng_valid_out (eng_valid_out),
        .out_ready     (out_ready),
        .out_wr        (out_wr),
        .out_ch        (out_ch),
        .out_col       (out_col),
        .err           (err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- engine model + monitor ----------------
    bit         inject = 1'b0;   // forced stray result pulse
    bit         eng_en = 1'b1;   // masks engine output (engine flush on abort)
    int         sess   = 0;      // bumped by the stimulus on every accepted start
    logic [3:0] pv = '0;
    int         pch[4];
    int         pcol[4];

    int kl_cnt[N];
    int iss_cnt[N];
    int wr_cnt[N];
    int wr_total = 0;
    int done_cnt = 0;

    int mon_sess = 0;
    int burst    = 0;
    int kcol     = 0;
    int ord      = 0;
    bit kl_prev  = 1'b0;

    assign eng_valid_out = (pv[3] && eng_en) || inject;

    always @(negedge clk) begin
        bit iss_now;
        int new_col;
        if (sess != mon_sess) begin
            mon_sess = sess;
            burst    = 0;
            kcol     = 0;
            ord      = 0;
            wr_total = 0;
            done_cnt = 0;
            for (int c = 0; c < N; c++) begin
                kl_cnt[c]  = 0;
                iss_cnt[c] = 0;
                wr_cnt[c]  = 0;
            end
        end
        if (kernel_load) begin
            if (!kl_prev) begin
                burst++;
                kcol = 0;
                ord  = 0;
            end
            check_eq("kern_col", int'(kern_col), kcol);
            check_eq("kern_idx", int'(kern_idx), burst - 1);
            check_eq("load_valid_in", int'(valid_in), 1);
            if (burst >= 1 && burst <= N) kl_cnt[burst-1]++;
            kcol++;
        end
        kl_prev = kernel_load;
        iss_now = 1'b0;
        new_col = 0;
        if (valid_in && !kernel_load) begin
            check_eq("img_col", int'(img_col), ord);
            if (burst >= 1 && burst <= N) iss_cnt[burst-1]++;
            if (ord >= K - 1) begin
                iss_now = 1'b1;
                new_col = ord - (K - 1);
            end
            ord++;
        end
        if (done) done_cnt++;
        for (int s = 3; s > 0; s--) begin
            pv[s]   = pv[s-1];
            pch[s]  = pch[s-1];
            pcol[s] = pcol[s-1];
        end
        pv[0]   = iss_now;
        pch[0]  = burst - 1;
        pcol[0] = new_col;
        #1;
        if (!inject) begin
            if (eng_valid_out) begin
                check_eq("res_wr", int'(out_wr), 1);
                check_eq("res_ch", int'(out_ch), pch[3]);
                check_eq("res_col", int'(out_col), pcol[3]);
            end else begin
                check_eq("no_wr", int'(out_wr), 0);
            end
        end
        if (out_wr) begin
            wr_total++;
            wr_cnt[out_ch]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_layer();
        @(negedge clk);
        start = 1'b1;
        sess++;
    endtask

    task automatic wait_done(input bit stall, input bit timing, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start     = 1'b0;
            out_ready = !(stall && (c % 3 == 0));
            if (timing && c <= K) begin
                check_eq("t_kernel_load", int'(kernel_load), 1);
                check_eq("t_kern_col", int'(kern_col), c - 1);
                check_eq("t_busy", int'(busy), 1);
            end
            if (timing && c == K + 1) begin
                check_eq("t_first_issue_kl", int'(kernel_load), 0);
                check_eq("t_first_issue_vi", int'(valid_in), 1);
                check_eq("t_first_issue_col", int'(img_col), 0);
            end
            if (done) begin
                cyc = c;
                break;
            end
        end
        if (cyc == 0) check_eq("layer_timeout", 0, 1);
        @(negedge clk);
        out_ready = 1'b1;
        check_eq("post_done_busy", int'(busy), 0);
        check_eq("post_done_done", int'(done), 0);
    endtask

    task automatic check_layer(input int exp_err);
        for (int c = 0; c < N; c++) begin
            check_eq("kl_cycles", kl_cnt[c], K);
            check_eq("issues", iss_cnt[c], I);
            check_eq("writes", wr_cnt[c], OC);
        end
        check_eq("writes_total", wr_total, N * OC);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("err", int'(err), exp_err);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_kernel_load"}, int'(kernel_load), 0);
        check_eq({tag, "_valid_in"}, int'(valid_in), 0);
        check_eq({tag, "_kern_idx"}, int'(kern_idx), 0);
        check_eq({tag, "_kern_col"}, int'(kern_col), 0);
        check_eq({tag, "_img_col"}, int'(img_col), 0);
        check_eq({tag, "_out_wr"}, int'(out_wr), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int  cyc;
        bit  found;

        // Reset values
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_err", int'(err), 0);
        check_eq("reset_out_ch", int'(out_ch), 0);
        check_eq("reset_out_col", int'(out_col), 0);
        rst = 1'b0;
        $display("scenario reset: checks=%0d", checks);

        // Full layer, no backpressure, cycle-exact timing
        start_layer();
        wait_done(1'b0, 1'b1, cyc);
        check_eq("done_cycle", cyc, LAYER_CYCLES);
        check_layer(0);
        $display("scenario full_layer: done in cycle %0d, writes=%0d", cyc, wr_total);

        // Backpressure: out_ready low every third cycle
        start_layer();
        wait_done(1'b1, 1'b0, cyc);
        check_layer(0);
        $display("scenario backpressure: done in cycle %0d, writes=%0d", cyc, wr_total);

        // Abort in STREAM of channel 2, then abort+start together in IDLE
        start_layer();
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            #2;
            if (iss_cnt[2] >= 10) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("abort_reach_ch2", int'(found), 1);
        @(negedge clk);
        abort  = 1'b1;
        eng_en = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("abort");
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_err", int'(err), 0);
        eng_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("abort_start_busy", int'(busy), 0);
        check_eq("abort_start_kl", int'(kernel_load), 0);
        @(negedge clk);
        check_eq("abort_start_busy2", int'(busy), 0);
        $display("scenario abort: busy=%0d done_pulses=%0d", busy, done_cnt);

        // Surplus 25th result in channel 0
        start_layer();
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            #2;
            if (wr_cnt[0] >= OC) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("extra_reach", int'(found), 1);
        @(negedge clk);
        inject = 1'b1;
        #1;
        check_eq("extra_no_wr", int'(out_wr), 0);
        @(negedge clk);
        inject = 1'b0;
        check_eq("extra_err", int'(err), 1);
        wait_done(1'b0, 1'b0, cyc);
        check_layer(1);
        repeat (3) @(negedge clk);
        check_eq("err_sticky", int'(err), 1);
        start_layer();
        @(negedge clk);
        start = 1'b0;
        check_eq("err_clear_on_start", int'(err), 0);
        check_eq("restart_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("restart_abort_busy", int'(busy), 0);
        $display("scenario surplus_result: ch0 writes=%0d", wr_cnt[0]);

        // Stray result while IDLE
        check_eq("idle_err_before", int'(err), 0);
        @(negedge clk);
        inject = 1'b1;
        #1;
        check_eq("idle_no_wr", int'(out_wr), 0);
        @(negedge clk);
        inject = 1'b0;
        check_eq("idle_err", int'(err), 1);
        $display("scenario idle_result: err=%0d", err);

        // Asynchronous reset in the middle of LOAD_K, then a fresh layer
        start_layer();
        repeat (3) @(negedge clk);
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        check_eq("rst_mid_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        start_layer();
        wait_done(1'b0, 1'b1, cyc);
        check_eq("rst_done_cycle", cyc, LAYER_CYCLES);
        check_layer(0);
        $display("scenario reset_mid_load: done in cycle %0d, writes=%0d", cyc, wr_total);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
